// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// seg_scan_if : load/display bus between a controller and seg_scan_driver
// Revision    : 1.0
// ============================================================================
interface seg_scan_if;
  logic [15:0] data_in;
  logic        load;
  logic        blank_en;
  logic        busy;
  logic [3:0]  digit_val;
  logic [7:0]  an;

  modport master (
    output data_in,
    output load,
    output blank_en,
    input  busy,
    input  digit_val,
    input  an
  );

  modport slave (
    input  data_in,
    input  load,
    input  blank_en,
    output busy,
    output digit_val,
    output an
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seg_scan_driver : 16-bit binary -> 5-digit BCD, multiplexed over 8 anodes
// Revision        : 1.0
// ============================================================================
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int             PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PS_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   bin_sr;
  logic [19:0]   bcd;
  logic [19:0]   bcd_adj;
  logic [19:0]   disp;
  logic [4:0]    iter;
  logic          busy_q;
  logic [PW-1:0] presc;
  logic [2:0]    idx;

  logic [3:0]    nibs [8];
  logic [7:0]    hi_zero;
  logic          slot_blank;

  // Add-3 correction on every BCD nibble ahead of the shift
  generate
    for (genvar k = 0; k < 5; k++) begin : g_adj
      assign bcd_adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? (bcd[4*k +: 4] + 4'd3)
                                                          : bcd[4*k +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      bin_sr <= '0;
      bcd    <= '0;
      iter   <= '0;
      disp   <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.load) begin
            bin_sr <= bus.data_in;
            bcd    <= '0;
            iter   <= '0;
            busy_q <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
          iter          <= iter + 5'd1;
          if (iter == 5'd15) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp   <= bcd;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PS_LAST) begin
      presc <= '0;
      idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Slots 5..7 are padded so a 3-bit index never selects out of range
  generate
    for (genvar k = 0; k < 8; k++) begin : g_slot
      if (k < 5) begin : g_live
        assign nibs[k]    = disp[4*k +: 4];
        assign hi_zero[k] = ~|(disp >> (4*k));
      end else begin : g_pad
        assign nibs[k]    = 4'h0;
        assign hi_zero[k] = 1'b0;
      end
    end
  endgenerate

  assign slot_blank    = bus.blank_en && (idx != 3'd0) && hi_zero[idx];
  assign bus.digit_val = slot_blank ? 4'hF : nibs[idx];
  assign bus.an        = ~(8'h01 << idx);

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// Randomized scoreboard bench for seg_scan_driver with REFRESH_DIV=4.
module tb_seg_scan_driver;

  logic clk;
  logic rst_n;
  seg_scan_if bus ();

  seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [19:0] expq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Decimal digits of v, slot 0 = units, with leading-zero blanking applied
  function automatic logic [19:0] model(input int v, input bit be);
    logic [19:0] r;
    int p;
    int d;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      d = (v / p) % 10;
      if (be && k > 0 && v < p) d = 15;
      r[4*k +: 4] = d[3:0];
      p = p * 10;
    end
    return r;
  endfunction

  // Reference scan position: cycles since the last reset edge
  int m_sc    = 0;
  bit m_valid = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_sc    = 0;
      m_valid = 1'b1;
    end else begin
      m_sc++;
    end
  end

  int          ph    = 0;
  int          blen  = 0;
  int          cnt   = 0;
  int          idx_m = 0;
  bit          have  = 1'b0;
  logic [19:0] cur   = '0;
  logic [3:0]  got [5];
  logic [7:0]  exp_an;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0;
    end else if (m_valid) begin
      idx_m  = (m_sc / 4) % 5;
      exp_an = ~(8'h01 << idx_m);
      check("an", {24'h0, bus.an}, {24'h0, exp_an});
      case (ph)
        0: begin
          if (bus.busy) begin
            ph   = 1;
            blen = 1;
          end
        end
        1: begin
          if (bus.busy) begin
            blen++;
          end else begin
            if (expq.size() == 0) begin
              total++;
              bad++;
              have = 1'b0;
              $display("FAIL unexpected_conversion: got busy window of %0d cycles want none", blen);
            end else begin
              cur  = expq.pop_front();
              have = 1'b1;
              check("busy_len", blen, 17);
            end
            got[idx_m] = bus.digit_val;
            cnt = 1;
            ph  = 2;
          end
        end
        default: begin
          got[idx_m] = bus.digit_val;
          cnt++;
          if (cnt == 20) begin
            if (have) begin
              for (int k = 0; k < 5; k++) begin
                check($sformatf("slot%0d", k), {28'h0, got[k]}, {28'h0, cur[4*k +: 4]});
              end
            end
            ph = 0;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_conv(input logic [15:0] v, input bit be);
    bus.blank_en = be;
    bus.data_in  = v;
    bus.load     = 1'b1;
    expq.push_back(model(int'(v), be));
    tick();
    bus.load = 1'b0;
    repeat (40) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.blank_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_an", {24'h0, bus.an}, 32'hFE);
    check("rst_digit", {28'h0, bus.digit_val}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (24) tick();

    do_conv(16'd12345, 1'b0);
    do_conv(16'd65535, 1'b0);
    do_conv(16'd42,    1'b1);
    do_conv(16'd42,    1'b0);
    do_conv(16'd0,     1'b1);

    // Second load lands on the 5th busy cycle and must be dropped
    bus.blank_en = 1'b0;
    bus.data_in  = 16'd100;
    bus.load     = 1'b1;
    expq.push_back(model(100, 1'b0));
    tick();
    bus.load = 1'b0;
    repeat (4) tick();
    bus.data_in = 16'd999;
    bus.load    = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (40) tick();

    for (int i = 0; i < 10; i++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 999)) : 16'($urandom);
      do_conv(v, 1'($urandom_range(0, 1)));
    end

    // Reset on the 8th SHIFT cycle aborts the 777 conversion
    bus.blank_en = 1'b0;
    bus.data_in  = 16'd777;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("abort_digit", {28'h0, bus.digit_val}, 32'h0);
      check("abort_busy", {31'h0, bus.busy}, 32'h0);
      tick();
    end
    do_conv(16'd9, 1'b1);

    repeat (5) tick();
    check("pending_expect", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
# seg_scan_driver

Upstream feeder for the 7-segment cathode encoder. Converts a 16-bit unsigned reading into 5 BCD digits using a sequential shift-add-3 (double-dabble) FSM. Time-multiplexes those digits across the board's 8 active-low anodes. Each scan slot presents one 4-bit digit code on `digit_val` for the encoder; code 4'hF is the blank code and lights no segments.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per scan slot (1 kHz per digit at 100 MHz); legal range ≥ 2.

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `data_in`  in  16: unsigned binary value to display.
- `load`  in  1: one-cycle strobe; samples `data_in` when idle.
- `blank_en`  in  1: leading-zero blanking enable; level input, sampled live.
- `busy`  out  1: conversion in progress; `load` is ignored while high.
- `digit_val`  out  4: digit code for the current slot (0–9, or 4'hF = blank) to the encoder.
- `an`  out  8: anode enables, active-low, one-hot-zero.

## Operation
- Converter FSM has three states:
  - IDLE: `load`=1 captures `data_in` into a 16-bit shift register, clears the 20-bit BCD accumulator and the 5-bit iteration counter, then goes to SHIFT.
  - SHIFT: each cycle, every BCD nibble ≥ 5 gets +3. The 36-bit {bcd, bin} vector then shifts left by 1. After 16 iterations, go to COMMIT.
  - COMMIT: copy the 20-bit BCD into the display register `disp`, then go to IDLE.
- `busy` = (state != IDLE). `load` in SHIFT or COMMIT is dropped and not queued.
- Arithmetic: every add-3 is done per nibble before the shift, in the same cycle. A 16-bit input gives at most 65535, so 5 nibbles never overflow.
- Scanner runs independently of the converter:
  - Prescaler counts 0..REFRESH_DIV-1. On its terminal count, slot index `idx` (0..4) advances, wrapping 4→0.
  - Anode positions 5..7 are never enabled.
- `an` = ~(8'b1 << idx). Bits 7:5 are always 1.
- `digit_val` = `disp` nibble `idx` (idx 0 = units), unless that slot is blanked. A blanked slot outputs 4'hF.
- Blanking rule:
  - With `blank_en`=1, slot k > 0 is blanked when nibbles k..4 of `disp` are all zero.
  - Slot 0 is never blanked.
  - With `blank_en`=0, nothing is blanked.
- `an` and `digit_val` are combinational decodes of the registered `idx`, `disp` and `blank_en`. They are glitch-free with respect to the FSM, since `disp` changes only in COMMIT.
- `disp` keeps its old value until COMMIT, so a conversion in progress never shows partial digits.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - State = IDLE, `busy`=0.
  - `disp`=0, `idx`=0, prescaler=0, iteration counter=0.
  - Outputs: `an`=8'hFE, `digit_val`=4'h0.
- Reset mid-conversion aborts the conversion. `disp` is forced to 0, so no stale result is committed.
- Load at cycle N (in IDLE):
  - SHIFT occupies cycles N+1..N+16 and COMMIT is cycle N+17.
  - `busy`=1 on cycles N+1..N+17.
  - The new digits appear on `digit_val` from cycle N+18.
  - Total latency is 18 cycles.
- Back-to-back: a `load` at N+18 (first IDLE cycle) is accepted. A `load` at N+17 is ignored.
- Slot change: `idx` advances on the edge where prescaler = REFRESH_DIV-1, and the prescaler returns to 0 on that same edge. Each slot is REFRESH_DIV cycles long; a full frame is 5×REFRESH_DIV cycles.
- COMMIT coinciding with a slot change: both take effect on the same edge. The new slot shows the new `disp` value.
- Changing `blank_en` affects `digit_val` in the same cycle (combinational path).

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold `rst_n`=0 for 3 cycles → `an`=8'hFE, `digit_val`=0, `busy`=0. After release, `an` steps FE→FD→FB→F7→EF→FE every 4 cycles.
- Conversion: `load` with `data_in`=12345 → `busy` high for exactly 17 cycles. Then slots 0..4 show 5,4,3,2,1.
- Maximum value: `data_in`=65535 → slots 0..4 show 5,3,5,5,6.
- Blanking with `data_in`=42:
  - `blank_en`=1 → slots 0..4 show 2,4,F,F,F.
  - `blank_en`=0 → slots 0..4 show 2,4,0,0,0.
  - `data_in`=0 with `blank_en`=1 → slots 0..4 show 0,F,F,F,F.
- Load while busy: `load` 100, then `load` 999 on the 5th busy cycle → only one 17-cycle busy window. Display shows 0,0,1,0,0.
- Mid-conversion reset: `load` 777, then `rst_n`=0 on the 8th SHIFT cycle → `busy`=0 and all slots show 0. A following `load` 9 shows 9 after 18 cycles.
